altavoz_tone_gen: RTL and testbench

Tone generator that consumes the four control registers written over AXI4-Lite into the altavoz slave and drives the speaker pin. On a start command it latches period, duration and volume into shadow registers, plays a square-wave tone, and amplitude-gates it with an 8-bit PWM carrier. It reports busy/done/remaining-time status back to the slave's read path. It sits directly downstream of the altavoz AXI4-Lite register file, in the same clock domain.

---
 rtl/altavoz_tone_gen.sv | 163 ++++++++++++++++
 tb/tb_altavoz_tone_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/altavoz_tone_gen.sv
// Speaker tone generator fed by the altavoz register file: latches a tone request,
// plays a PWM-gated square wave for a tick-counted duration and reports status.
module altavoz_tone_gen #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned TICK_DIV    = 100000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] ctrl_reg,
  input  logic [31:0] period_reg,
  input  logic [31:0] duration_reg,
  input  logic [31:0] volume_reg,
  output logic        speaker_out,
  output logic        busy,
  output logic        done_pulse,
  output logic [15:0] ticks_remaining
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                start_q;
  logic                stop_q;
  logic [23:0]         period_sh_q;
  logic [8:0]          vol_sh_q;
  logic                cont_sh_q;
  logic [23:0]         half_cnt_q;
  logic                phase_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [15:0]         ticks_q;
  logic [7:0]          pwm_cnt_q;
  logic                speaker_q;
  logic                busy_q;
  logic                done_q;

  logic                start_rise;
  logic                stop_rise;
  logic [8:0]          vol_clamped;
  logic                play_req;
  logic                unused_bits;

  assign start_rise  = ctrl_reg[0] & ~start_q;
  assign stop_rise   = ctrl_reg[3] & ~stop_q;
  assign vol_clamped = (volume_reg[8:0] > 9'd256) ? 9'd256 : volume_reg[8:0];
  assign play_req    = ctrl_reg[1] | (duration_reg[15:0] != 16'd0);

  assign unused_bits = &{1'b0, ctrl_reg[31:4], period_reg[31:24], duration_reg[31:16],
                         volume_reg[31:9], CLK_FREQ_HZ[0]};

  // Control FSM, tone/tick/PWM counters and all registered outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      period_sh_q <= 24'd0;
      vol_sh_q    <= 9'd0;
      cont_sh_q   <= 1'b0;
      half_cnt_q  <= 24'd0;
      phase_q     <= 1'b0;
      tick_cnt_q  <= '0;
      ticks_q     <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      speaker_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_q   <= ctrl_reg[0];
      stop_q    <= ctrl_reg[3];
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      speaker_q <= (state_q == ST_PLAY) & phase_q & ({1'b0, pwm_cnt_q} < vol_sh_q) & ~ctrl_reg[2];
      done_q    <= 1'b0;

      case (state_q)
        ST_IDLE, ST_PLAY: begin
          // Stop outranks start in the same cycle.
          if (stop_rise) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            ticks_q    <= 16'd0;
            phase_q    <= 1'b0;
            half_cnt_q <= 24'd0;
            tick_cnt_q <= '0;
          end else if (start_rise) begin
            period_sh_q <= period_reg[23:0];
            vol_sh_q    <= vol_clamped;
            cont_sh_q   <= ctrl_reg[1];
            if (play_req) begin
              state_q    <= ST_PLAY;
              busy_q     <= 1'b1;
              ticks_q    <= duration_reg[15:0];
              tick_cnt_q <= TICK_RELOAD;
              phase_q    <= (period_reg[23:0] != 24'd0);
              half_cnt_q <= (period_reg[23:0] == 24'd0) ? 24'd0 : period_reg[23:0] - 24'd1;
            end else begin
              state_q    <= ST_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              ticks_q    <= 16'd0;
              phase_q    <= 1'b0;
              half_cnt_q <= 24'd0;
              tick_cnt_q <= '0;
            end
          end else if (state_q == ST_PLAY) begin
            if (period_sh_q == 24'd0) begin
              phase_q    <= 1'b0;
              half_cnt_q <= 24'd0;
            end else if (half_cnt_q == 24'd0) begin
              phase_q    <= ~phase_q;
              half_cnt_q <= period_sh_q - 24'd1;
            end else begin
              half_cnt_q <= half_cnt_q - 24'd1;
            end

            if (tick_cnt_q == '0) begin
              tick_cnt_q <= TICK_RELOAD;
              if (cont_sh_q) begin
                ticks_q <= ticks_q;
              end else if (ticks_q == 16'd1) begin
                state_q    <= ST_DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                ticks_q    <= 16'd0;
                phase_q    <= 1'b0;
                half_cnt_q <= 24'd0;
              end else begin
                ticks_q <= ticks_q - 16'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q - TICK_W'(1);
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ticks_q <= 16'd0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ticks_q <= 16'd0;
          phase_q <= 1'b0;
        end
      endcase
    end
  end

  assign speaker_out     = speaker_q;
  assign busy            = busy_q;
  assign done_pulse      = done_q;
  assign ticks_remaining = ticks_q;

endmodule

// File: tb/tb_altavoz_tone_gen.sv
// Directed bench for altavoz_tone_gen with TICK_DIV=10 and hand-computed expectations.
module tb_altavoz_tone_gen;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] ctrl_reg = 32'd0;
  logic [31:0] period_reg = 32'd0;
  logic [31:0] duration_reg = 32'd0;
  logic [31:0] volume_reg = 32'd0;
  logic        speaker_out;
  logic        busy;
  logic        done_pulse;
  logic [15:0] ticks_remaining;

  int n_checks = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  altavoz_tone_gen #(.TICK_DIV(10)) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .ctrl_reg        (ctrl_reg),
    .period_reg      (period_reg),
    .duration_reg    (duration_reg),
    .volume_reg      (volume_reg),
    .speaker_out     (speaker_out),
    .busy            (busy),
    .done_pulse      (done_pulse),
    .ticks_remaining (ticks_remaining)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {13'd0, speaker_out, busy, done_pulse, ticks_remaining};
  endfunction

  initial begin
    int hc;
    int bc;
    int dc;
    int so;
    logic [31:0] exp_tr;

    // Reset
    #100;
    check("rst_outputs", all_outs(), 32'd0);
    #100;
    ARESETN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_outputs", all_outs(), 32'd0);
    end

    // Basic tone: period 4, duration 3 ticks of 10 cycles, full volume
    period_reg = 32'd4; duration_reg = 32'd3; volume_reg = 32'd256; ctrl_reg = 32'd1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      exp_tr = (i < 10) ? 32'd3 : (i < 20) ? 32'd2 : (i < 30) ? 32'd1 : 32'd0;
      check("basic_busy", 32'(busy), 32'(i < 30));
      check("basic_done", 32'(done_pulse), 32'(i == 30));
      check("basic_ticks", 32'(ticks_remaining), exp_tr);
      check("basic_speaker", 32'(speaker_out), 32'((i >= 1) && (i <= 30) && (((i - 1) % 8) < 4)));
    end
    ctrl_reg = 32'd0; cyc();

    // PWM duty 64/256 inside the first high half-period, then mute, then stop
    period_reg = 32'd1000; duration_reg = 32'd50; volume_reg = 32'd64; ctrl_reg = 32'd1;
    hc = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (i >= 10 && i <= 265) hc += int'(speaker_out);
    end
    check("pwm_duty", 32'(hc), 32'd64);
    check("pwm_busy", 32'(busy), 32'd1);
    ctrl_reg = 32'd5;
    so = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      so += int'(speaker_out);
    end
    check("mute_speaker", 32'(so), 32'd0);
    ctrl_reg = 32'd8; cyc();
    check("pwm_stop_busy", 32'(busy), 32'd0);
    check("pwm_stop_done", 32'(done_pulse), 32'd0);
    ctrl_reg = 32'd0; cyc();

    // Volume 0 keeps the speaker silent for the whole play
    period_reg = 32'd4; duration_reg = 32'd3; volume_reg = 32'd0; ctrl_reg = 32'd1;
    so = 0; bc = 0;
    for (int i = 0; i < 35; i++) begin
      cyc();
      so += int'(speaker_out);
      bc += int'(busy);
    end
    check("vol0_speaker", 32'(so), 32'd0);
    check("vol0_busy_len", 32'(bc), 32'd30);
    ctrl_reg = 32'd0; cyc();

    // Continuous play, then stop
    period_reg = 32'd4; duration_reg = 32'd7; volume_reg = 32'd256; ctrl_reg = 32'd3;
    for (int i = 0; i < 50; i++) begin
      cyc();
      check("cont_busy", 32'(busy), 32'd1);
      check("cont_ticks", 32'(ticks_remaining), 32'd7);
    end
    ctrl_reg = 32'hB; cyc();
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_done", 32'(done_pulse), 32'd0);
    check("stop_ticks", 32'(ticks_remaining), 32'd0);
    dc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      dc += int'(done_pulse) + int'(busy);
    end
    check("stop_no_retrigger", 32'(dc), 32'd0);
    ctrl_reg = 32'd0; cyc();

    // Start and stop together
    duration_reg = 32'd3; ctrl_reg = 32'd9; cyc();
    check("both_busy0", 32'(busy), 32'd0);
    check("both_done0", 32'(done_pulse), 32'd0);
    cyc();
    check("both_busy1", 32'(busy), 32'd0);
    ctrl_reg = 32'd0; cyc();

    // Zero duration
    duration_reg = 32'd0; ctrl_reg = 32'd1; cyc();
    check("zero_done", 32'(done_pulse), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    cyc();
    check("zero_done_end", 32'(done_pulse), 32'd0);
    check("zero_busy_end", 32'(busy), 32'd0);
    ctrl_reg = 32'd0; cyc();

    // Period 0: silent but duration still timed
    period_reg = 32'd0; duration_reg = 32'd2; volume_reg = 32'd256; ctrl_reg = 32'd1;
    bc = 0; so = 0; dc = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (i == 0) check("p0_ticks", 32'(ticks_remaining), 32'd2);
      bc += int'(busy);
      so += int'(speaker_out);
      dc += int'(done_pulse);
    end
    check("p0_busy_len", 32'(bc), 32'd20);
    check("p0_speaker", 32'(so), 32'd0);
    check("p0_done_count", 32'(dc), 32'd1);
    ctrl_reg = 32'd0; cyc();

    // Restart mid-play with a new duration
    period_reg = 32'd4; duration_reg = 32'd3; ctrl_reg = 32'd1;
    for (int i = 0; i < 16; i++) cyc();
    check("restart_pre_ticks", 32'(ticks_remaining), 32'd2);
    ctrl_reg = 32'd0; cyc();
    duration_reg = 32'd5; ctrl_reg = 32'd1; cyc();
    check("restart_ticks", 32'(ticks_remaining), 32'd5);
    check("restart_busy", 32'(busy), 32'd1);
    bc = 1; dc = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      bc += int'(busy);
      dc += int'(done_pulse);
    end
    check("restart_busy_len", 32'(bc), 32'd50);
    check("restart_done_count", 32'(dc), 32'd1);
    ctrl_reg = 32'd0; cyc();

    // Reset 15 cycles into play
    duration_reg = 32'd5; ctrl_reg = 32'd1;
    for (int i = 0; i < 16; i++) cyc();
    check("midrst_pre_busy", 32'(busy), 32'd1);
    ARESETN = 1'b0; ctrl_reg = 32'd0;
    #2;
    check("midrst_outputs", all_outs(), 32'd0);
    cyc(); cyc();
    ARESETN = 1'b1;
    dc = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      dc += int'(done_pulse) + int'(busy) + int'(speaker_out);
    end
    check("midrst_quiet", 32'(dc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
